// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the BCD stopwatch.
//   stopwatch_state_e : run-control states
//   BCD_W / BCD_MAX   : nibble width and largest legal digit
//   bcd_clamp()       : saturates a nibble to a legal BCD digit
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUNNING = 2'd1,
      PAUSED  = 2'd2
   } stopwatch_state_e;

   localparam int         BCD_W   = 4;
   localparam logic [3:0] BCD_MAX = 4'd9;

   function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] nib);
      return (nib > BCD_MAX) ? BCD_MAX : nib;
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the stopwatch count chain.
//   clk, rst  : clock, synchronous active-high reset
//   load_en   : load load_val (clamped to 9) this cycle; overrides stepping
//   en_in     : step this digit by one in the direction given by up
//   up        : 1 = increment, 0 = decrement
//   digit     : current digit value, always 0..9
//   en_out    : step enable for the next digit (carry on 9->0, borrow on 0->9)
module bcd_digit
   import stopwatch_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load_en,
   input  logic [BCD_W-1:0] load_val,
   input  logic             en_in,
   input  logic             up,
   output logic [BCD_W-1:0] digit,
   output logic             en_out
);

   logic [BCD_W-1:0] digit_q, digit_d;

   assign en_out = en_in && (up ? (digit_q == BCD_MAX) : (digit_q == '0));
   assign digit  = digit_q;

   always_comb begin
      digit_d = digit_q;
      if (load_en) begin
         digit_d = bcd_clamp(load_val);
      end else if (en_in) begin
         if (up) begin
            digit_d = (digit_q >= BCD_MAX) ? '0 : digit_q + 4'd1;
         end else begin
            digit_d = (digit_q == '0) ? BCD_MAX : digit_q - 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         digit_q <= '0;
      end else begin
         digit_q <= digit_d;
      end
   end

endmodule

// File: rtl/bcd_stopwatch_core.sv
// N-digit BCD stopwatch core with internal tick prescaler.
//   clk, rst     : clock, synchronous active-high reset
//   start_stop   : pulse, toggles run/pause (IDLE starts a fresh period)
//   clear        : pulse, zero count and return to IDLE
//   lap          : pulse, toggles display freeze while running
//   load         : pulse, preset count from load_value (nibbles clamped to 9)
//   load_value   : BCD preset, digit 0 in [3:0]
//   count_down   : level, 1 = decrement
//   display_bcd  : frozen snapshot while lap_active, otherwise live count
//   count_bcd    : live count
//   running      : high in RUNNING
//   lap_active   : display frozen
//   tick         : high on the cycle a count step is taken
//   wrap, done   : one-cycle pulses alongside the updated count
//
// state   | meaning
// IDLE    | cleared / after reset, prescaler parked, no counting
// RUNNING | prescaler counting, count steps on each terminal count
// PAUSED  | prescaler and count held; resume continues the same period
module bcd_stopwatch_core
   import stopwatch_pkg::*;
#(
   parameter int CLK_FREQ_HZ   = 100000000,
   parameter int TICK_HZ       = 10,
   parameter int NUM_DIGITS    = 4,
   parameter int STOP_AT_LIMIT = 0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start_stop,
   input  logic                        clear,
   input  logic                        lap,
   input  logic                        load,
   input  logic [BCD_W*NUM_DIGITS-1:0] load_value,
   input  logic                        count_down,
   output logic [BCD_W*NUM_DIGITS-1:0] display_bcd,
   output logic [BCD_W*NUM_DIGITS-1:0] count_bcd,
   output logic                        running,
   output logic                        lap_active,
   output logic                        tick,
   output logic                        wrap,
   output logic                        done
);

   localparam int             DIV       = CLK_FREQ_HZ / TICK_HZ;
   localparam int             PW        = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int             CW        = BCD_W * NUM_DIGITS;
   localparam logic [PW-1:0]  PRESC_TOP = PW'(DIV - 1);

   stopwatch_state_e state_q, state_d;
   // Down-counter of cycles left in the current tick period; 0 is terminal.
   logic [PW-1:0]    presc_q, presc_d;
   logic             lap_q, lap_d;
   logic [CW-1:0]    snap_q, snap_d;
   logic             wrap_q, wrap_d;
   logic             done_q, done_d;

   logic [CW-1:0]       count;
   logic [CW-1:0]       digit_load_val;
   logic                digit_load;
   logic                step_en;
   logic [NUM_DIGITS:0] en_chain;
   logic                tc;
   logic                all_nines, is_zero, upper_zero, is_one;

   assign tc = (state_q == RUNNING) && (presc_q == '0);

   always_comb begin
      all_nines  = 1'b1;
      is_zero    = 1'b1;
      upper_zero = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (count[i*BCD_W +: BCD_W] != BCD_MAX) all_nines = 1'b0;
         if (count[i*BCD_W +: BCD_W] != '0)      is_zero   = 1'b0;
      end
      for (int i = 1; i < NUM_DIGITS; i++) begin
         if (count[i*BCD_W +: BCD_W] != '0) upper_zero = 1'b0;
      end
      is_one = upper_zero && (count[BCD_W-1:0] == 4'd1);
   end

   always_comb begin
      state_d        = state_q;
      presc_d        = presc_q;
      lap_d          = lap_q;
      snap_d         = snap_q;
      done_d         = 1'b0;
      step_en        = 1'b0;
      digit_load     = 1'b0;
      digit_load_val = '0;

      if (clear) begin
         state_d    = IDLE;
         presc_d    = PRESC_TOP;
         lap_d      = 1'b0;
         digit_load = 1'b1;
      end else if (load) begin
         presc_d        = PRESC_TOP;
         lap_d          = 1'b0;
         digit_load     = 1'b1;
         digit_load_val = load_value;
      end else begin
         if (state_q == RUNNING) begin
            presc_d = tc ? PRESC_TOP : presc_q - 1'b1;
         end

         if (tc) begin
            if (!count_down) begin
               if (all_nines && (STOP_AT_LIMIT != 0)) begin
                  state_d = PAUSED;
               end else begin
                  step_en = 1'b1;
               end
            end else begin
               // A zero count is held rather than borrowed into all-9s.
               step_en = !is_zero;
               if (is_zero || is_one) begin
                  done_d  = 1'b1;
                  state_d = PAUSED;
               end
            end
         end

         if (start_stop) begin
            case (state_q)
               IDLE: begin
                  state_d = RUNNING;
                  presc_d = PRESC_TOP;
               end
               RUNNING: state_d = PAUSED;
               default: state_d = RUNNING;
            endcase
         end else if (lap) begin
            if (state_q == RUNNING) begin
               lap_d = !lap_q;
               if (!lap_q) snap_d = count;
            end else if (state_q == PAUSED) begin
               lap_d = 1'b0;
            end
         end
      end
   end

   // Only an up step can ripple out of the top digit: down steps from zero are blocked.
   assign wrap_d      = en_chain[NUM_DIGITS];
   assign en_chain[0] = step_en;

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
      bcd_digit u_digit (
         .clk      (clk),
         .rst      (rst),
         .load_en  (digit_load),
         .load_val (digit_load_val[g*BCD_W +: BCD_W]),
         .en_in    (en_chain[g]),
         .up       (!count_down),
         .digit    (count[g*BCD_W +: BCD_W]),
         .en_out   (en_chain[g+1])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         presc_q <= PRESC_TOP;
         lap_q   <= 1'b0;
         snap_q  <= '0;
         wrap_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         lap_q   <= lap_d;
         snap_q  <= snap_d;
         wrap_q  <= wrap_d;
         done_q  <= done_d;
      end
   end

   assign count_bcd   = count;
   assign display_bcd = lap_q ? snap_q : count;
   assign running     = (state_q == RUNNING);
   assign lap_active  = lap_q;
   assign tick        = tc;
   assign wrap        = wrap_q;
   assign done        = done_q;

endmodule

// File: tb/tb_bcd_stopwatch_core.sv
module tb_bcd_stopwatch_core;

   localparam int DIV  = 10;
   localparam int MAXV = 9999;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start_stop = 1'b0, clear = 1'b0, lap = 1'b0, load = 1'b0;
   logic [15:0] load_value = '0;
   logic        count_down = 1'b0;

   logic [15:0] disp_o [2];
   logic [15:0] cnt_o  [2];
   logic        run_o  [2];
   logic        lap_o  [2];
   logic        tick_o [2];
   logic        wrap_o [2];
   logic        done_o [2];

   int total = 0;
   int bad   = 0;

   // Reference: count as a plain integer, period position as elapsed cycles.
   int m_val  [2];
   int m_st   [2];   // 0 idle, 1 running, 2 paused
   int m_el   [2];
   int m_lap  [2];
   int m_snap [2];
   int m_wrap [2];
   int m_done [2];
   int done_seen0 = 0;

   always #5 clk = ~clk;

   bcd_stopwatch_core #(.CLK_FREQ_HZ(100), .TICK_HZ(10), .NUM_DIGITS(4), .STOP_AT_LIMIT(0)) u_dut0 (
      .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear), .lap(lap), .load(load),
      .load_value(load_value), .count_down(count_down),
      .display_bcd(disp_o[0]), .count_bcd(cnt_o[0]), .running(run_o[0]), .lap_active(lap_o[0]),
      .tick(tick_o[0]), .wrap(wrap_o[0]), .done(done_o[0]));

   bcd_stopwatch_core #(.CLK_FREQ_HZ(100), .TICK_HZ(10), .NUM_DIGITS(4), .STOP_AT_LIMIT(1)) u_dut1 (
      .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear), .lap(lap), .load(load),
      .load_value(load_value), .count_down(count_down),
      .display_bcd(disp_o[1]), .count_bcd(cnt_o[1]), .running(run_o[1]), .lap_active(lap_o[1]),
      .tick(tick_o[1]), .wrap(wrap_o[1]), .done(done_o[1]));

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      int d;
      d = v;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         r[i*4 +: 4] = 4'(d % 10);
         d = d / 10;
      end
      return r;
   endfunction

   function automatic int preset_value(input logic [15:0] lv);
      int v, mult, nib;
      v = 0;
      mult = 1;
      for (int i = 0; i < 4; i++) begin
         nib = int'(lv[i*4 +: 4]);
         if (nib > 9) nib = 9;
         v = v + nib * mult;
         mult = mult * 10;
      end
      return v;
   endfunction

   task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s[%0d] got=%h exp=%h", nm, k, got, exp);
      end
   endtask

   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         int old_val, old_st, nst;
         bit tk;
         m_wrap[k] = 0;
         m_done[k] = 0;
         if (rst) begin
            m_val[k] = 0; m_st[k] = 0; m_el[k] = 0; m_lap[k] = 0; m_snap[k] = 0;
         end else if (clear) begin
            m_val[k] = 0; m_st[k] = 0; m_el[k] = 0; m_lap[k] = 0;
         end else if (load) begin
            m_val[k] = preset_value(load_value); m_el[k] = 0; m_lap[k] = 0;
         end else begin
            old_val = m_val[k];
            old_st  = m_st[k];
            nst     = old_st;
            tk      = (old_st == 1) && (m_el[k] == DIV - 1);
            if (old_st == 1) m_el[k] = tk ? 0 : m_el[k] + 1;
            if (tk) begin
               if (!count_down) begin
                  if (old_val == MAXV) begin
                     if (k == 1) nst = 2;
                     else begin m_val[k] = 0; m_wrap[k] = 1; end
                  end else m_val[k] = old_val + 1;
               end else begin
                  if (old_val <= 1) begin m_val[k] = 0; m_done[k] = 1; nst = 2; end
                  else m_val[k] = old_val - 1;
               end
            end
            if (start_stop) begin
               if (old_st == 0) begin nst = 1; m_el[k] = 0; end
               else if (old_st == 1) nst = 2;
               else nst = 1;
            end else if (lap) begin
               if (old_st == 1) begin
                  if (m_lap[k] == 0) m_snap[k] = old_val;
                  m_lap[k] = (m_lap[k] == 0) ? 1 : 0;
               end else if (old_st == 2) m_lap[k] = 0;
            end
            m_st[k] = nst;
         end
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < 2; k++) begin
         logic [15:0] ec;
         ec = to_bcd(m_val[k]);
         chk("count_bcd", k, 32'(cnt_o[k]), 32'(ec));
         chk("display_bcd", k, 32'(disp_o[k]), 32'(m_lap[k] != 0 ? to_bcd(m_snap[k]) : ec));
         chk("running", k, 32'(run_o[k]), 32'(m_st[k] == 1));
         chk("lap_active", k, 32'(lap_o[k]), 32'(m_lap[k] != 0));
         chk("tick", k, 32'(tick_o[k]), 32'((m_st[k] == 1) && (m_el[k] == DIV - 1)));
         chk("wrap", k, 32'(wrap_o[k]), 32'(m_wrap[k] != 0));
         chk("done", k, 32'(done_o[k]), 32'(m_done[k] != 0));
      end
      if (done_o[0]) done_seen0++;
   endtask

   // One clock: DUT and model both take the edge, outputs compared mid-cycle,
   // then all single-cycle pulses are dropped.
   task automatic cyc();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
      rst = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0; load = 1'b0;
   endtask

   task automatic wait_tick(output int n);
      n = 0;
      while (!tick_o[0] && n < 100) begin
         cyc();
         n++;
      end
      if (n >= 100) chk("tick_timeout", 0, 32'(n), 32'd0);
   endtask

   initial begin
      int n, ticks;
      for (int k = 0; k < 2; k++) begin
         m_val[k] = 0; m_st[k] = 0; m_el[k] = 0; m_lap[k] = 0;
         m_snap[k] = 0; m_wrap[k] = 0; m_done[k] = 0;
      end
      @(negedge clk);

      // reset state
      rst = 1'b1; cyc();
      chk("rst_count", 0, 32'(cnt_o[0]), 32'h0);
      chk("rst_running", 0, 32'(run_o[0]), 32'h0);

      // first tick DIV cycles after start, BCD accumulation
      start_stop = 1'b1; cyc();
      wait_tick(n);
      chk("first_tick_delay", 0, 32'(n), 32'd9);
      cyc();
      chk("first_count", 0, 32'(cnt_o[0]), 32'h0001);
      ticks = 1;
      n = 0;
      while (ticks < 123 && n < 2000) begin
         cyc();
         n++;
         if (tick_o[0]) ticks++;
      end
      cyc();
      chk("count_123", 0, 32'(cnt_o[0]), 32'h0123);

      // up limit: wrap vs stop
      load_value = 16'h9998; load = 1'b1; cyc();
      wait_tick(n); cyc();
      chk("limit_9999", 0, 32'(cnt_o[0]), 32'h9999);
      wait_tick(n); cyc();
      chk("wrap_count", 0, 32'(cnt_o[0]), 32'h0000);
      chk("wrap_pulse", 0, 32'(wrap_o[0]), 32'h1);
      chk("stop_count", 1, 32'(cnt_o[1]), 32'h9999);
      chk("stop_running", 1, 32'(run_o[1]), 32'h0);
      chk("stop_wrap", 1, 32'(wrap_o[1]), 32'h0);

      // down count to zero
      clear = 1'b1; cyc();
      count_down = 1'b1; load_value = 16'h0003; load = 1'b1; cyc();
      start_stop = 1'b1; cyc();
      done_seen0 = 0;
      wait_tick(n); cyc();
      chk("down_2", 0, 32'(cnt_o[0]), 32'h0002);
      wait_tick(n); cyc();
      wait_tick(n); cyc();
      chk("down_0", 0, 32'(cnt_o[0]), 32'h0000);
      chk("down_done", 0, 32'(done_o[0]), 32'h1);
      chk("down_running", 0, 32'(run_o[0]), 32'h0);
      repeat (30) cyc();
      chk("done_once", 0, 32'(done_seen0), 32'd1);

      // lap freeze
      clear = 1'b1; cyc();
      count_down = 1'b0; load_value = 16'h0042; load = 1'b1; cyc();
      start_stop = 1'b1; cyc();
      repeat (3) cyc();
      lap = 1'b1; cyc();
      n = 0;
      while (cnt_o[0] != 16'h0050 && n < 200) begin cyc(); n++; end
      chk("lap_frozen", 0, 32'(disp_o[0]), 32'h0042);
      chk("lap_live", 0, 32'(cnt_o[0]), 32'h0050);
      lap = 1'b1; cyc();
      chk("lap_release", 0, 32'(disp_o[0]), 32'h0050);

      // pause mid-period, resume continues the period
      clear = 1'b1; cyc();
      start_stop = 1'b1; cyc();
      repeat (3) cyc();
      start_stop = 1'b1; cyc();
      repeat (100) cyc();
      chk("paused_running", 0, 32'(run_o[0]), 32'h0);
      start_stop = 1'b1; cyc();
      wait_tick(n);
      chk("resume_delay", 0, 32'(n), 32'd5);
      clear = 1'b1; start_stop = 1'b1; cyc();
      chk("clear_wins_run", 0, 32'(run_o[0]), 32'h0);
      chk("clear_wins_cnt", 0, 32'(cnt_o[0]), 32'h0);

      // load clamp, reset mid-run
      load_value = 16'hA5F0; load = 1'b1; cyc();
      chk("load_clamp", 0, 32'(cnt_o[0]), 32'h9590);
      start_stop = 1'b1; cyc();
      repeat (15) cyc();
      rst = 1'b1; cyc();
      chk("rst_mid_cnt", 0, 32'(cnt_o[0]), 32'h0);
      chk("rst_mid_run", 0, 32'(run_o[0]), 32'h0);
      chk("rst_mid_disp", 0, 32'(disp_o[0]), 32'h0);

      // randomized traffic
      for (int i = 0; i < 6000; i++) begin
         int r;
         r = int'($urandom_range(0, 999));
         if (r < 2) rst = 1'b1;
         if (r >= 2 && r < 8) clear = 1'b1;
         if (r >= 8 && r < 18) begin
            load = 1'b1;
            case ($urandom_range(0, 3))
               0: load_value = 16'h9995;
               1: load_value = 16'h0004;
               default: load_value = 16'($urandom);
            endcase
         end
         if ($urandom_range(0, 99) < 3) start_stop = 1'b1;
         if ($urandom_range(0, 99) < 3) lap = 1'b1;
         if ($urandom_range(0, 199) == 0) count_down = ~count_down;
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
